lcd_bus_receiver: RTL and testbench

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

---
 rtl/lcd_bus_receiver.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
//   Snoops the HD44780-style 4-bit LCD bus that the LCD driver produces and
//   rebuilds the byte stream: init nibbles, command/data bytes, and the
//   DDRAM address counter that a real controller would keep.
//
// Ports
//   Clock                   system clock, all logic on the rising edge
//   Reset                   synchronous, active-high
//   iLCD_Enabled            E strobe
//   iLCD_RegisterSelect     RS (0 command, 1 data)
//   iLCD_ReadWrite          R/W (reads are not supported -> fault)
//   iLCD_StrataFlashControl SF_CE0, must be high while the LCD is addressed
//   iLCD_Data[3:0]          DB7..DB4
//   oByte/oByteIsData       last assembled byte and its RS
//   oByteValid              one-cycle pulse, new byte available
//   oCharWrite/oCharAddr    one-cycle pulse, data byte written at oCharAddr
//   oCursorAddr             DDRAM address counter
//   oFourBitMode            4-bit handoff done
//   oFault                  one-cycle pulse on a protocol violation
module lcd_bus_receiver #(
  parameter int EN_MIN_CYCLES = 12,
  parameter int LINE_LEN      = 40
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic       iLCD_StrataFlashControl,
  input  logic [3:0] iLCD_Data,
  output logic [7:0] oByte,
  output logic       oByteIsData,
  output logic       oByteValid,
  output logic       oCharWrite,
  output logic [6:0] oCharAddr,
  output logic [6:0] oCursorAddr,
  output logic       oFourBitMode,
  output logic       oFault
);

  localparam logic [7:0] EN_MIN      = 8'(EN_MIN_CYCLES);
  localparam logic [6:0] LINE1_END   = 7'(LINE_LEN - 1);
  localparam logic [6:0] LINE2_START = 7'h40;
  localparam logic [6:0] LINE2_END   = 7'(64 + LINE_LEN - 1);

  typedef enum logic [1:0] {
    ST_INIT8 = 2'd0,
    ST_HI    = 2'd1,
    ST_LO    = 2'd2
  } state_t;

  state_t stateQ, stateN;

  // input register stage
  logic       enR, enRR, rsR, rwR, sfR;
  logic [3:0] dataR;

  // bus values from the last cycle E was high
  logic [3:0] capNib;
  logic       capRs, capRw, capSf;

  logic [7:0] highCnt;
  logic       blocked;     // strobe straddling reset release is ignored
  logic [3:0] hiNib, hiNibN;
  logic       hiRs, hiRsN;

  logic [7:0] byteN;
  logic       isDataN, validN, charWrN, fourN, faultN;
  logic [6:0] charAddrN, cursorN;

  logic       fall, accept, badStrobe;
  logic [7:0] asm;

  // DDRAM counter increment: line 1 end jumps to line 2, line 2 end and
  // anything beyond wraps home, the hole between lines lands on line 2.
  function automatic logic [6:0] incAddr(input logic [6:0] a);
    logic [6:0] r;
    if (a == LINE1_END)                    r = LINE2_START;
    else if (a >= LINE2_END)               r = 7'h00;
    else if (a > LINE1_END && a < LINE2_START) r = LINE2_START;
    else                                   r = a + 7'd1;
    return r;
  endfunction

  assign fall      = enRR && !enR;
  assign accept    = fall && !blocked && (highCnt >= EN_MIN) && !capRw && capSf;
  assign badStrobe = fall && !blocked && !accept;
  assign asm       = {hiNib, capNib};

  // state register
  always_ff @(posedge Clock) begin
    if (Reset) stateQ <= ST_INIT8;
    else       stateQ <= stateN;
  end

  // next state and next output values
  always_comb begin
    stateN    = stateQ;
    hiNibN    = hiNib;
    hiRsN     = hiRs;
    fourN     = oFourBitMode;
    byteN     = oByte;
    isDataN   = oByteIsData;
    validN    = 1'b0;
    charWrN   = 1'b0;
    charAddrN = oCharAddr;
    cursorN   = oCursorAddr;
    faultN    = badStrobe;
    case (stateQ)
      ST_INIT8: begin
        if (accept && capNib == 4'h2 && !capRs) begin
          stateN = ST_HI;
          fourN  = 1'b1;
        end
      end
      ST_HI: begin
        if (accept) begin
          hiNibN = capNib;
          hiRsN  = capRs;
          stateN = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          stateN = ST_HI;
          if (capRs != hiRs) begin
            faultN = 1'b1;
          end else begin
            byteN   = asm;
            isDataN = capRs;
            validN  = 1'b1;
            if (capRs) begin
              charWrN   = 1'b1;
              charAddrN = oCursorAddr;
              cursorN   = incAddr(oCursorAddr);
            end else if (asm[7]) begin
              cursorN = asm[6:0];
            end else if (asm == 8'h01 || asm == 8'h02 || asm == 8'h03) begin
              cursorN = 7'h00;
            end
          end
        end
      end
      default: stateN = ST_INIT8;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      enR          <= 1'b0;
      enRR         <= 1'b0;
      rsR          <= 1'b0;
      rwR          <= 1'b0;
      sfR          <= 1'b0;
      dataR        <= 4'h0;
      capNib       <= 4'h0;
      capRs        <= 1'b0;
      capRw        <= 1'b0;
      capSf        <= 1'b0;
      highCnt      <= 8'd0;
      blocked      <= 1'b1;
      hiNib        <= 4'h0;
      hiRs         <= 1'b0;
      oByte        <= 8'h00;
      oByteIsData  <= 1'b0;
      oByteValid   <= 1'b0;
      oCharWrite   <= 1'b0;
      oCharAddr    <= 7'h00;
      oCursorAddr  <= 7'h00;
      oFourBitMode <= 1'b0;
      oFault       <= 1'b0;
    end else begin
      enR   <= iLCD_Enabled;
      enRR  <= enR;
      rsR   <= iLCD_RegisterSelect;
      rwR   <= iLCD_ReadWrite;
      sfR   <= iLCD_StrataFlashControl;
      dataR <= iLCD_Data;
      if (enR) begin
        capNib <= dataR;
        capRs  <= rsR;
        capRw  <= rwR;
        capSf  <= sfR;
      end
      highCnt <= enR ? ((highCnt == 8'hFF) ? highCnt : highCnt + 8'd1) : 8'd0;
      // Clear once the bus is seen idle, or once the straddling strobe ends
      // (its falling edge is still discarded because blocked is set then).
      if (fall || (!enR && !iLCD_Enabled)) blocked <= 1'b0;
      hiNib        <= hiNibN;
      hiRs         <= hiRsN;
      oByte        <= byteN;
      oByteIsData  <= isDataN;
      oByteValid   <= validN;
      oCharWrite   <= charWrN;
      oCharAddr    <= charAddrN;
      oCursorAddr  <= cursorN;
      oFourBitMode <= fourN;
      oFault       <= faultN;
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
module tb_lcd_bus_receiver;
  logic       clk = 1'b0;
  logic       Reset, En, Rs, Rw, Sf;
  logic [3:0] Data;
  logic [7:0] oByte;
  logic       oByteIsData, oByteValid, oCharWrite, oFourBitMode, oFault;
  logic [6:0] oCharAddr, oCursorAddr;

  lcd_bus_receiver #(.EN_MIN_CYCLES(12), .LINE_LEN(40)) dut (
    .Clock(clk), .Reset(Reset),
    .iLCD_Enabled(En), .iLCD_RegisterSelect(Rs), .iLCD_ReadWrite(Rw),
    .iLCD_StrataFlashControl(Sf), .iLCD_Data(Data),
    .oByte(oByte), .oByteIsData(oByteIsData), .oByteValid(oByteValid),
    .oCharWrite(oCharWrite), .oCharAddr(oCharAddr), .oCursorAddr(oCursorAddr),
    .oFourBitMode(oFourBitMode), .oFault(oFault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       isData;
    logic       wr;
    logic [6:0] addr;
    int         due;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  int cyc = 0, faultCnt = 0, expFaults = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (oFault === 1'b1) faultCnt++;
    if (oByteValid === 1'b1 || oCharWrite === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_byte", 32'(oByte), 32'hFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("byte", 32'(oByte), 32'(e.b));
        check("byte_valid", 32'(oByteValid), 32'd1);
        check("byte_is_data", 32'(oByteIsData), 32'(e.isData));
        check("char_write", 32'(oCharWrite), 32'(e.wr));
        if (e.wr) check("char_addr", 32'(oCharAddr), 32'(e.addr));
        check("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // one E strobe; optionally pushes the byte it should complete
  task automatic strobe(input logic [3:0] nib, input logic rs, input int hi,
                        input logic rw, input logic sf,
                        input logic push, input exp_t e);
    @(negedge clk);
    Data = nib; Rs = rs; Rw = rw; Sf = sf; En = 1'b1;
    repeat (hi) @(negedge clk);
    if (push) begin
      e.due = cyc + 2;
      q.push_back(e);
    end
    En = 1'b0;
    repeat (5) @(negedge clk);
    Rw = 1'b0; Sf = 1'b1;
  endtask

  task automatic nib(input logic [3:0] n, input logic rs);
    exp_t e;
    e = '{8'h00, 1'b0, 1'b0, 7'h00, 0};
    strobe(n, rs, 12, 1'b0, 1'b1, 1'b0, e);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic rs, input logic [6:0] addr);
    exp_t e;
    e = '{b, rs, rs, addr, 0};
    nib(b[7:4], rs);
    strobe(b[3:0], rs, 12, 1'b0, 1'b1, 1'b1, e);
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic badStrobe(input logic [3:0] n, input int hi, input logic rw, input logic sf);
    exp_t e;
    e = '{8'h00, 1'b0, 1'b0, 7'h00, 0};
    strobe(n, 1'b0, hi, rw, sf, 1'b0, e);
    expFaults++;
    check("fault_count", 32'(faultCnt), 32'(expFaults));
  endtask

  initial begin
    Reset = 1'b1; En = 1'b0; Rs = 1'b0; Rw = 1'b0; Sf = 1'b1; Data = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_byte", 32'(oByte), 32'h0);
    check("rst_valid", 32'(oByteValid), 32'h0);
    check("rst_cursor", 32'(oCursorAddr), 32'h0);
    check("rst_4bit", 32'(oFourBitMode), 32'h0);
    check("rst_fault", 32'(oFault), 32'h0);
    Reset = 1'b0;
    repeat (3) @(negedge clk);

    // init handoff
    nib(4'h3, 1'b0);
    check("init_still_8bit", 32'(oFourBitMode), 32'h0);
    nib(4'h3, 1'b0);
    nib(4'h3, 1'b0);
    nib(4'h2, 1'b0);
    check("init_4bit", 32'(oFourBitMode), 32'h1);

    // commands
    sendByte(8'h28, 1'b0, 7'h00);
    sendByte(8'h01, 1'b0, 7'h00);
    check("cursor_after_clear", 32'(oCursorAddr), 32'h00);

    // line 1 end wraps to line 2
    sendByte(8'hA7, 1'b0, 7'h00);
    check("cursor_set_27", 32'(oCursorAddr), 32'h27);
    sendByte(8'h41, 1'b1, 7'h27);
    check("cursor_wrap_40", 32'(oCursorAddr), 32'h40);

    // line 2 end wraps home
    sendByte(8'hE7, 1'b0, 7'h00);
    check("cursor_set_67", 32'(oCursorAddr), 32'h67);
    sendByte(8'h42, 1'b1, 7'h67);
    check("cursor_wrap_00", 32'(oCursorAddr), 32'h00);

    // protocol faults
    badStrobe(4'h8, 5, 1'b0, 1'b1);
    badStrobe(4'h8, 12, 1'b1, 1'b1);
    badStrobe(4'h8, 12, 1'b0, 1'b0);
    check("cursor_after_faults", 32'(oCursorAddr), 32'h00);

    // a fault between nibbles leaves the byte assembly intact
    begin
      exp_t e;
      e = '{8'h85, 1'b0, 1'b0, 7'h00, 0};
      nib(4'h8, 1'b0);
      badStrobe(4'h3, 5, 1'b0, 1'b1);
      strobe(4'h5, 1'b0, 12, 1'b0, 1'b1, 1'b1, e);
      check("cursor_set_05", 32'(oCursorAddr), 32'h05);
    end

    // RS change between nibbles: byte dropped
    nib(4'h4, 1'b0);
    nib(4'h1, 1'b1);
    expFaults++;
    check("rs_mismatch_fault", 32'(faultCnt), 32'(expFaults));
    check("rs_mismatch_cursor", 32'(oCursorAddr), 32'h05);
    sendByte(8'h43, 1'b1, 7'h05);
    check("cursor_06", 32'(oCursorAddr), 32'h06);

    // out-of-range addresses
    sendByte(8'hB0, 1'b0, 7'h00);
    sendByte(8'h44, 1'b1, 7'h30);
    check("gap_to_40", 32'(oCursorAddr), 32'h40);
    sendByte(8'hF0, 1'b0, 7'h00);
    sendByte(8'h45, 1'b1, 7'h70);
    check("high_to_00", 32'(oCursorAddr), 32'h00);

    // home
    sendByte(8'h90, 1'b0, 7'h00);
    sendByte(8'h02, 1'b0, 7'h00);
    check("home", 32'(oCursorAddr), 32'h00);
    sendByte(8'h85, 1'b0, 7'h00);

    // reset mid-byte
    nib(4'h4, 1'b1);
    @(negedge clk); Reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_byte", 32'(oByte), 32'h0);
    check("mid_rst_cursor", 32'(oCursorAddr), 32'h0);
    check("mid_rst_charaddr", 32'(oCharAddr), 32'h0);
    check("mid_rst_4bit", 32'(oFourBitMode), 32'h0);
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    nib(4'h1, 1'b1);
    check("post_rst_no_byte", 32'(q.size()), 32'd0);
    check("post_rst_4bit", 32'(oFourBitMode), 32'h0);

    // strobe straddling reset release is ignored
    @(negedge clk);
    Reset = 1'b1; Data = 4'h2; Rs = 1'b0; En = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    repeat (15) @(negedge clk);
    En = 1'b0;
    repeat (5) @(negedge clk);
    check("straddle_ignored", 32'(oFourBitMode), 32'h0);
    nib(4'h2, 1'b0);
    check("recover_4bit", 32'(oFourBitMode), 32'h1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
